// File: rtl/training_sample_streamer.sv
// Training-set RAM plus streaming FSM: delivers stored samples in address order
// over a valid/ready handshake for a programmable number of epochs.
module training_sample_streamer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned N_IN    = 2,
    parameter int unsigned N_OUT   = 1,
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned EPOCH_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_en,
    input  logic [ADDR_W-1:0]         load_addr,
    input  logic [N_IN*DATA_W-1:0]    load_x,
    input  logic [N_OUT*DATA_W-1:0]   load_y,
    input  logic [ADDR_W:0]           num_samples,
    input  logic [EPOCH_W-1:0]        num_epochs,
    input  logic                      start,
    input  logic                      abort,
    output logic [N_IN*DATA_W-1:0]    x_out,
    output logic [N_OUT*DATA_W-1:0]   y_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         address,
    output logic [EPOCH_W-1:0]        epoch,
    output logic                      last_in_epoch,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned X_W   = N_IN * DATA_W;
    localparam int unsigned Y_W   = N_OUT * DATA_W;
    localparam int unsigned S_W   = X_W + Y_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

    state_t              r_state;
    logic [S_W-1:0]      r_mem [DEPTH];
    logic [S_W-1:0]      r_rd_data;
    logic [CNT_W-1:0]    r_num_samples;
    logic [EPOCH_W-1:0]  r_num_epochs;
    logic [ADDR_W-1:0]   r_address;
    logic [EPOCH_W-1:0]  r_epoch;
    logic                r_last;

    logic                w_idle;
    logic                w_cfg_ok;
    logic                w_start;
    logic                w_hs;
    logic                w_wrap;
    logic                w_final;
    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_rd_addr;

    assign w_idle      = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_cfg_ok    = (num_samples != '0) && (num_samples <= CNT_W'(DEPTH)) && (num_epochs != '0);
    assign w_start     = start && !abort && w_idle && w_cfg_ok;
    assign w_hs        = (r_state == S_STREAM) && out_ready && !abort;
    assign w_wrap      = ({1'b0, r_address} == (r_num_samples - CNT_W'(1)));
    assign w_final     = (r_epoch == (r_num_epochs - EPOCH_W'(1)));
    assign w_next_addr = w_wrap ? '0 : r_address + ADDR_W'(1);
    // Next sample is fetched on the handshake edge itself so streaming has no bubbles.
    assign w_rd_en     = w_start || (w_hs && !(w_wrap && w_final));
    assign w_rd_addr   = w_start ? '0 : w_next_addr;

    always_ff @(posedge clk) begin
        if (load_en && w_idle) begin
            r_mem[load_addr] <= {load_y, load_x};
        end
    end

    // RAM read register doubles as the x_out/y_out output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_num_samples <= '0;
            r_num_epochs  <= '0;
            r_address     <= '0;
            r_epoch       <= '0;
            r_last        <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state       <= S_FETCH;
                        r_num_samples <= num_samples;
                        r_num_epochs  <= num_epochs;
                        r_address     <= '0;
                        r_epoch       <= '0;
                        r_last        <= (num_samples == CNT_W'(1));
                    end
                end
                S_FETCH: begin
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (w_wrap && w_final) begin
                            r_state <= S_DONE;
                        end else begin
                            r_address <= w_next_addr;
                            r_last    <= ({1'b0, w_next_addr} == (r_num_samples - CNT_W'(1)));
                            if (w_wrap) begin
                                r_epoch <= r_epoch + EPOCH_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x_out         = r_rd_data[X_W-1:0];
    assign y_out         = r_rd_data[S_W-1:X_W];
    assign address       = r_address;
    assign epoch         = r_epoch;
    assign last_in_epoch = r_last;
    assign out_valid     = (r_state == S_STREAM);
    assign busy          = (r_state == S_FETCH) || (r_state == S_STREAM);
    assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_training_sample_streamer.sv
// Randomized bench for training_sample_streamer against a shadow-RAM sequence model.
module tb_training_sample_streamer;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned N_IN    = 2;
    localparam int unsigned N_OUT   = 1;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned EPOCH_W = 16;
    localparam int unsigned XW      = N_IN * DATA_W;
    localparam int unsigned YW      = N_OUT * DATA_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [XW-1:0]      load_x;
    logic [YW-1:0]      load_y;
    logic [ADDR_W:0]    num_samples;
    logic [EPOCH_W-1:0] num_epochs;
    logic               start;
    logic               abort;
    logic [XW-1:0]      x_out;
    logic [YW-1:0]      y_out;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  address;
    logic [EPOCH_W-1:0] epoch;
    logic               last_in_epoch;
    logic               busy;
    logic               done;

    logic [XW-1:0] mx [DEPTH];
    logic [YW-1:0] my [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    training_sample_streamer #(
        .DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT),
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .EPOCH_W(EPOCH_W)
    ) dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_addr(load_addr), .load_x(load_x), .load_y(load_y),
        .num_samples(num_samples), .num_epochs(num_epochs),
        .start(start), .abort(abort),
        .x_out(x_out), .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready),
        .address(address), .epoch(epoch), .last_in_epoch(last_in_epoch),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic load_set(input int n, input bit pattern);
        logic [XW-1:0] lx;
        logic [YW-1:0] ly;
        for (int a = 0; a < n; a++) begin
            @(posedge clk); #1;
            if (pattern) begin
                lx = {DATA_W'(a + 1), DATA_W'(-(a + 1))};
                ly = YW'(a);
            end else begin
                lx = XW'({$urandom(), $urandom()});
                ly = YW'($urandom());
            end
            load_en   = 1'b1;
            load_addr = ADDR_W'(a);
            load_x    = lx;
            load_y    = ly;
            mx[a]     = lx;
            my[a]     = ly;
        end
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic pulse_start(input int n, input int e);
        @(posedge clk); #1;
        num_samples = (ADDR_W + 1)'(n);
        num_epochs  = EPOCH_W'(e);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Start a run and check every handshake against the expected address/epoch sequence.
    task automatic run_stream(input int n, input int e, input int pct, input bit scribble, input string tag);
        int total, hs, cycles, budget, a_exp, e_exp;
        bit first, stall, rdy;
        logic [XW-1:0]     sx;
        logic [YW-1:0]     sy;
        logic [ADDR_W-1:0] sa;
        total  = n * e;
        budget = total * 20 + 20;
        hs = 0; cycles = 0; first = 1'b1; stall = 1'b0;
        sx = '0; sy = '0; sa = '0;
        out_ready = 1'b0;
        pulse_start(n, e);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_fetch: out_valid=%b busy=%b, want 0 1", tag, out_valid, busy);
        end
        while (hs < total && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
            if (scribble) begin
                load_en   = 1'b1;
                load_addr = ADDR_W'($urandom_range(DEPTH - 1));
                load_x    = XW'({$urandom(), $urandom()});
                load_y    = YW'($urandom());
            end
            if (first) begin
                first = 1'b0;
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_latency: out_valid=%b two cycles after start, want 1", tag, out_valid);
                end
            end
            if (stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || x_out !== sx || y_out !== sy || address !== sa) begin
                    n_fail++;
                    $display("FAIL %s_stall: valid=%b x=%h y=%h addr=%0d, want 1 %h %h %0d",
                             tag, out_valid, x_out, y_out, address, sx, sy, sa);
                end
            end
            if (out_valid === 1'b1) begin
                rdy = ($urandom_range(99) < pct);
                out_ready = rdy;
                stall = !rdy;
                sx = x_out; sy = y_out; sa = address;
                if (rdy) begin
                    a_exp = hs % n;
                    e_exp = hs / n;
                    n_checks++;
                    if (x_out !== mx[a_exp] || y_out !== my[a_exp] || address !== ADDR_W'(a_exp) ||
                        epoch !== EPOCH_W'(e_exp) || last_in_epoch !== (a_exp == n - 1)) begin
                        n_fail++;
                        $display("FAIL %s_sample%0d: x=%h y=%h addr=%0d ep=%0d last=%b, want %h %h %0d %0d %b",
                                 tag, hs, x_out, y_out, address, epoch, last_in_epoch,
                                 mx[a_exp], my[a_exp], a_exp, e_exp, (a_exp == n - 1));
                    end
                    hs++;
                end
            end else begin
                out_ready = 1'b0;
                stall = 1'b0;
            end
        end
        load_en = 1'b0;
        n_checks++;
        if (hs != total) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d handshakes, want %0d", tag, hs, total);
        end
        if (pct >= 100) begin
            n_checks++;
            if (cycles != total) begin
                n_fail++;
                $display("FAIL %s_bubbles: %0d cycles for stream, want %0d", tag, cycles, total);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done=%b valid=%b busy=%b, want 1 0 0", tag, done, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_x = '0; load_y = '0;
        num_samples = '0; num_epochs = '0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (x_out !== '0 || y_out !== '0 || address !== '0 || epoch !== '0) begin
            n_fail++;
            $display("FAIL reset_data: x=%h y=%h addr=%0d ep=%0d, want 0", x_out, y_out, address, epoch);
        end
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || last_in_epoch !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b last=%b, want 0", out_valid, busy, done, last_in_epoch);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet: valid=%b busy=%b, want 0 0", out_valid, busy);
            end
        end
    endtask

    task automatic test_basic();
        load_set(4, 1'b1);
        run_stream(4, 3, 100, 1'b0, "basic");
    endtask

    task automatic test_invalid_cfg();
        int ns [3] = '{0, DEPTH + 1, 4};
        int ne [3] = '{3, 3, 0};
        for (int i = 0; i < 3; i++) begin
            pulse_start(ns[i], ne[i]);
            n_checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_cfg%0d: busy=%b valid=%b done=%b, want 0 0 1", i, busy, out_valid, done);
            end
        end
    endtask

    task automatic test_backpressure();
        run_stream(4, 3, 50, 1'b0, "backpressure");
    endtask

    task automatic test_single();
        run_stream(1, 5, 100, 1'b0, "single");
    endtask

    task automatic test_full_depth();
        load_set(DEPTH, 1'b0);
        run_stream(DEPTH, 2, 70, 1'b0, "full_depth");
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        pulse_start(4, 3);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (address !== ADDR_W'(1) || epoch !== EPOCH_W'(1) || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: addr=%0d ep=%0d valid=%b, want 1 1 1", address, epoch, out_valid);
        end
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || address !== ADDR_W'(1) || epoch !== EPOCH_W'(1)) begin
            n_fail++;
            $display("FAIL abort_idle: valid=%b busy=%b done=%b addr=%0d ep=%0d, want 0 0 0 1 1",
                     out_valid, busy, done, address, epoch);
        end
        run_stream(4, 2, 100, 1'b0, "restart");
    endtask

    task automatic test_load_during_stream();
        run_stream(4, 2, 60, 1'b1, "scribble");
        run_stream(DEPTH, 1, 100, 1'b0, "after_scribble");
    endtask

    task automatic test_async_reset();
        pulse_start(4, 3);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || address !== '0 || x_out !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b busy=%b addr=%0d x=%h done=%b, want 0 0 0 0 0",
                     out_valid, busy, address, x_out, done);
        end
        out_ready = 1'b0;
        #10;
        reset = 1'b1;
        load_set(4, 1'b0);
        run_stream(4, 2, 100, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid_cfg();
        test_backpressure();
        test_single();
        test_full_depth();
        test_abort();
        test_load_during_stream();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/training_sample_streamer.md
Name: training_sample_streamer

Overview:
- Parametrised successor to the fixed two-input, one-label training data wrapper.
- Holds a training set of DEPTH samples, each with N_IN feature words and N_OUT label words, in on-chip RAM.
- Streams the samples to the neural network top with a valid/ready handshake, in address order, for a programmable number of epochs.
- Wraps the address each epoch and reports the epoch count, the last sample of each epoch and completion.

Parameters:
- DATA_W, 16, width of one feature or label word (signed fixed point, opaque to this block)
- N_IN, 2, feature words per sample
- N_OUT, 1, label words per sample
- DEPTH, 2048, sample storage capacity
- ADDR_W, $clog2(DEPTH), sample address width
- EPOCH_W, 16, epoch counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_en  in  1  write one sample into RAM this cycle
- load_addr  in  ADDR_W  sample write address
- load_x  in  N_IN*DATA_W  features; word k is at bits [k*DATA_W +: DATA_W]
- load_y  in  N_OUT*DATA_W  labels, packed the same way as load_x
- num_samples  in  ADDR_W+1  samples per epoch, 1..DEPTH; sampled on start
- num_epochs  in  EPOCH_W  epoch count, at least 1; sampled on start
- start  in  1  begin streaming (one-cycle pulse)
- abort  in  1  stop streaming and return to IDLE
- x_out  out  N_IN*DATA_W  current sample features
- y_out  out  N_OUT*DATA_W  current sample labels
- out_valid  out  1  x_out/y_out hold a valid sample
- out_ready  in  1  consumer accepts the sample
- address  out  ADDR_W  index of the presented sample
- epoch  out  EPOCH_W  current epoch, zero-based
- last_in_epoch  out  1  presented sample is address num_samples-1
- busy  out  1  state is FETCH or STREAM
- done  out  1  all epochs delivered; sticky

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. RAM contents are undefined after reset.
- Register outputs x_out, y_out, address, epoch and last_in_epoch; out_valid, busy and done are decoded from the state register.
- RAM:
  - One synchronous write port and one synchronous read port; read latency 1 cycle.
  - load_en is honoured only in IDLE or DONE. It is ignored while busy.
- FSM states: IDLE, FETCH, STREAM, DONE.
- IDLE / DONE on start:
  - If num_samples is 0, num_samples > DEPTH, or num_epochs is 0: start is ignored and the state is unchanged.
  - Otherwise: latch the config, set address=0 and epoch=0, issue read of address 0, clear done, go to FETCH.
- FETCH:
  - Lasts exactly 1 cycle. Next state is STREAM; out_valid rises on entry to STREAM.
  - Latency from start to first out_valid is 2 cycles.
- STREAM:
  - Hold out_valid=1 and keep x_out, y_out and address stable until out_ready=1.
  - Handshake = out_valid && out_ready. On handshake, the next address is issued to the read port in the same cycle.
  - This gives one sample per cycle with out_ready held high, and no bubbles across the epoch wrap.
- Handshake at address < num_samples-1: address increments.
- Handshake at address = num_samples-1:
  - If epoch < num_epochs-1: address wraps to 0 and epoch increments; stay in STREAM.
  - Otherwise: go to DONE with out_valid=0 and done=1.
- num_samples=1: every handshake wraps, and last_in_epoch stays 1 throughout.
- abort has priority over start and over a handshake in the same cycle.
  - Next state is IDLE with out_valid=0 and done=0.
  - address and epoch keep their last values.
- start while busy is ignored.
- Asserting reset mid-stream forces the reset values immediately, without waiting for a clock edge.
- epoch does not overflow, because num_epochs ≤ 2^EPOCH_W-1.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset low, then release with no start.
  - Required: all outputs 0 and out_valid stays 0.
- Basic stream:
  - Stimulus: load 4 samples with x = {addr+1, -(addr+1)} and y = addr; num_samples=4, num_epochs=3; start; out_ready=1.
  - Required: first valid 2 cycles after start, then 12 consecutive handshakes.
  - Required: address runs 0,1,2,3 three times and epoch runs 0→2; last_in_epoch is high at address 3.
  - Required: done=1 in the cycle after the 12th handshake.
- Backpressure:
  - Stimulus: toggle out_ready randomly at 50%.
  - Required: x_out, y_out and address never change while out_valid && !out_ready; same data order as the basic stream.
- Edge configs:
  - Stimulus: num_samples=1 with num_epochs=5.
  - Required: 5 samples, all at address 0, epoch 0→4.
  - Stimulus: start with num_epochs=0, or with num_samples=DEPTH+1.
  - Required: stays IDLE with busy=0.
- Abort and restart:
  - Stimulus: abort during the second epoch, then start again.
  - Required: IDLE next cycle; the restart begins from address 0, epoch 0.
  - Stimulus: load_en during the stream.
  - Required: RAM contents are unchanged.
- Asynchronous reset:
  - Stimulus: assert reset between clock edges mid-stream.
  - Required: out_valid falls without waiting for a clock edge; after release a new start streams correctly.
